// File: rtl/octagon_orbit_sprite.sv
// Per-frame sprite motion controller: latched WASD velocity (MANUAL) or a
// continuous octagon traversal (ORBIT) with reversal, lap counting and recentre.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_MANUAL | position advances by the latched WASD velocity
// ST_ORBIT  | position walks the octagon segments, one STEP per frame
module octagon_orbit_sprite #(
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 245,
    parameter int R        = 45,
    parameter int C        = 15,
    parameter int STEP     = 1,
    parameter int SIZE     = 8,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] BallS,
    output logic       orbit_active,
    output logic [2:0] seg_idx,
    output logic [7:0] lap_count,
    output logic       lap_done
);

    localparam logic [9:0]        HOME_X = 10'(X_CENTER + C);
    localparam logic [9:0]        HOME_Y = 10'(Y_CENTER - R);
    localparam logic [9:0]        LEN_S  = 10'(2 * C / STEP);
    localparam logic [9:0]        LEN_D  = 10'((R - C) / STEP);
    localparam logic signed [10:0] S_STEP = 11'(STEP);
    localparam logic signed [10:0] S_SIZE = 11'(SIZE);
    localparam logic signed [10:0] S_XMIN = 11'(X_MIN);
    localparam logic signed [10:0] S_XMAX = 11'(X_MAX);
    localparam logic signed [10:0] S_YMIN = 11'(Y_MIN);
    localparam logic signed [10:0] S_YMAX = 11'(Y_MAX);

    typedef enum logic {ST_MANUAL = 1'b0, ST_ORBIT = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [9:0]          r_x, r_y, w_x_nxt, w_y_nxt;
    logic signed [10:0]  r_mx, r_my, w_mx_nxt, w_my_nxt;
    logic                r_dir, w_dir_nxt;          // 0 = CCW, 1 = CW
    logic [2:0]          r_seg, w_seg_nxt, w_seg_fwd, w_seg_back;
    logic [9:0]          r_rem, w_rem_nxt, w_rem_rev;
    logic [7:0]          r_lap, w_lap_nxt;
    logic                r_lap_done, w_lap_done_nxt;
    logic [7:0]          r_prev_key;
    logic                r_edge_mask;
    logic                w_key_new, w_space_edge, w_rev_edge, w_key_wasd, w_oob;
    logic signed [10:0]  w_key_mx, w_key_my, w_dx, w_dy, w_sx, w_sy;

    function automatic logic [9:0] f_len(input logic [2:0] s);
        return s[0] ? LEN_D : LEN_S;
    endfunction

    function automatic logic signed [10:0] f_dx(input logic [2:0] s);
        case (s)
            3'd0, 3'd1, 3'd7: f_dx = -S_STEP;
            3'd3, 3'd4, 3'd5: f_dx = S_STEP;
            default:          f_dx = '0;
        endcase
    endfunction

    function automatic logic signed [10:0] f_dy(input logic [2:0] s);
        case (s)
            3'd1, 3'd2, 3'd3: f_dy = S_STEP;
            3'd5, 3'd6, 3'd7: f_dy = -S_STEP;
            default:          f_dy = '0;
        endcase
    endfunction

    function automatic logic [9:0] f_add(input logic [9:0] p, input logic signed [10:0] d);
        logic signed [10:0] t;
        t = $signed({1'b0, p}) + d;
        return t[9:0];
    endfunction

    // A key already held across reset must not register as an edge.
    assign w_key_new    = (keycode != r_prev_key) && !r_edge_mask;
    assign w_space_edge = w_key_new && (keycode == 8'h2C);
    assign w_rev_edge   = w_key_new && (keycode == 8'h15);

    always_comb begin
        w_key_wasd = 1'b1;
        w_key_mx   = '0;
        w_key_my   = '0;
        case (keycode)
            8'h04:   w_key_mx = -S_STEP;
            8'h07:   w_key_mx = S_STEP;
            8'h16:   w_key_my = S_STEP;
            8'h1A:   w_key_my = -S_STEP;
            default: w_key_wasd = 1'b0;
        endcase
    end

    assign w_sx  = $signed({1'b0, r_x});
    assign w_sy  = $signed({1'b0, r_y});
    assign w_oob = (w_sx + S_SIZE >= S_XMAX) || (w_sx - S_SIZE <= S_XMIN) ||
                   (w_sy + S_SIZE >= S_YMAX) || (w_sy - S_SIZE <= S_YMIN);

    assign w_dx       = r_dir ? -f_dx(r_seg) : f_dx(r_seg);
    assign w_dy       = r_dir ? -f_dy(r_seg) : f_dy(r_seg);
    assign w_seg_fwd  = r_dir ? r_seg - 3'd1 : r_seg + 3'd1;
    assign w_seg_back = r_dir ? r_seg + 3'd1 : r_seg - 3'd1;
    assign w_rem_rev  = f_len(r_seg) - r_rem;

    always_ff @(posedge frame_clk) begin
        if (Reset)    r_state <= ST_MANUAL;
        else if (Run) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_oob) begin
            w_state_nxt = ST_MANUAL;
        end else begin
            case (r_state)
                ST_MANUAL: if (w_space_edge) w_state_nxt = ST_ORBIT;
                ST_ORBIT:  if (w_key_wasd)   w_state_nxt = ST_MANUAL;
                default:   w_state_nxt = ST_MANUAL;
            endcase
        end
    end

    always_comb begin
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_mx_nxt       = r_mx;
        w_my_nxt       = r_my;
        w_dir_nxt      = r_dir;
        w_seg_nxt      = r_seg;
        w_rem_nxt      = r_rem;
        w_lap_nxt      = r_lap;
        w_lap_done_nxt = 1'b0;
        if (w_oob) begin
            w_x_nxt  = HOME_X;
            w_y_nxt  = HOME_Y;
            w_mx_nxt = '0;
            w_my_nxt = '0;
        end else if (r_state == ST_MANUAL) begin
            if (w_space_edge) begin
                w_x_nxt   = HOME_X;
                w_y_nxt   = HOME_Y;
                w_mx_nxt  = '0;
                w_my_nxt  = '0;
                w_seg_nxt = r_dir ? 3'd7 : 3'd0;
                w_rem_nxt = r_dir ? LEN_D : LEN_S;
            end else begin
                if (w_key_wasd) begin
                    w_mx_nxt = w_key_mx;
                    w_my_nxt = w_key_my;
                end
                if (w_rev_edge) w_dir_nxt = ~r_dir;
                w_x_nxt = f_add(r_x, w_mx_nxt);
                w_y_nxt = f_add(r_y, w_my_nxt);
            end
        end else if (w_key_wasd) begin
            w_mx_nxt = w_key_mx;
            w_my_nxt = w_key_my;
            w_x_nxt  = f_add(r_x, w_key_mx);
            w_y_nxt  = f_add(r_y, w_key_my);
        end else if (w_rev_edge) begin
            w_dir_nxt = ~r_dir;
            if (w_rem_rev == '0) begin
                w_seg_nxt = w_seg_back;
                w_rem_nxt = f_len(w_seg_back);
            end else begin
                w_rem_nxt = w_rem_rev;
            end
        end else begin
            w_x_nxt = f_add(r_x, w_dx);
            w_y_nxt = f_add(r_y, w_dy);
            if (r_rem == 10'd1) begin
                w_seg_nxt = w_seg_fwd;
                w_rem_nxt = f_len(w_seg_fwd);
                if ((!r_dir && r_seg == 3'd7) || (r_dir && r_seg == 3'd0)) begin
                    w_lap_nxt      = r_lap + 8'd1;
                    w_lap_done_nxt = 1'b1;
                end
            end else begin
                w_rem_nxt = r_rem - 10'd1;
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_x         <= HOME_X;
            r_y         <= HOME_Y;
            r_mx        <= '0;
            r_my        <= '0;
            r_dir       <= 1'b0;
            r_seg       <= 3'd0;
            r_rem       <= LEN_S;
            r_lap       <= '0;
            r_lap_done  <= 1'b0;
            r_prev_key  <= '0;
            r_edge_mask <= 1'b1;
        end else begin
            r_prev_key <= keycode;
            if (Run) begin
                r_x         <= w_x_nxt;
                r_y         <= w_y_nxt;
                r_mx        <= w_mx_nxt;
                r_my        <= w_my_nxt;
                r_dir       <= w_dir_nxt;
                r_seg       <= w_seg_nxt;
                r_rem       <= w_rem_nxt;
                r_lap       <= w_lap_nxt;
                r_lap_done  <= w_lap_done_nxt;
                r_edge_mask <= 1'b0;
            end
        end
    end

    always_comb begin
        BallX        = r_x;
        BallY        = r_y;
        BallS        = 10'(SIZE);
        orbit_active = (r_state == ST_ORBIT);
        seg_idx      = r_seg;
        lap_count    = r_lap;
        lap_done     = r_lap_done;
    end

endmodule
